axi_rd_burst_arbiter: RTL and testbench

//  Burst-aware read-data (R) channel arbiter and mux for the interconnect master port.

---
 rtl/axi_ic_pkg.sv | 24 ++
 rtl/axi_rd_burst_arbiter_rr_pick.sv | 45 ++++
 rtl/axi_rd_burst_arbiter.sv | 156 +++++++++++++++
 tb/tb_axi_rd_burst_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_ic_pkg                                                     |
// | Description : Shared definitions for the AXI interconnect arbiters:          |
// |               RRESP encodings, arbiter state type and counter width.         |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package axi_ic_pkg;

   localparam logic [1:0] RRESP_OKAY   = 2'b00;
   localparam logic [1:0] RRESP_EXOKAY = 2'b01;
   localparam logic [1:0] RRESP_SLVERR = 2'b10;
   localparam logic [1:0] RRESP_DECERR = 2'b11;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_BURST = 1'b1
   } arb_state_e;

   // Width of the optional per-slave completed-burst counters.
   localparam int ARB_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/axi_rd_burst_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                        |
// | Description : Combinational round-robin picker. Returns the one-hot first    |
// |               asserted request at or after ptr_i, wrapping modulo N_REQ.     |
// |               Shared by the AW/AR/R/B arbiters.                              |
// | Ports       : req_i  [N_REQ]  request vector                                 |
// |               ptr_i  [PTR_W]  highest-priority index (must be < N_REQ)       |
// |               gnt_o  [N_REQ]  one-hot winner, 0 when no request              |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module rr_pick
   import axi_ic_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_o
);

   logic found;

   // Two passes: first the requesters at or above the pointer, then the
   // wrapped-around ones below it. The first hit wins.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_i[i] && (PTR_W'(i) >= ptr_i)) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req_i[i]) begin
            gnt_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_rd_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_rd_burst_arbiter                                           |
// | Description : Burst-aware AXI R-channel arbiter/mux. Shares one master R     |
// |               channel between N_SLV slave R channels, round-robin, holding   |
// |               the grant until the RLAST beat handshakes.                     |
// | Ports       : sys_clk/sys_rstn    clock, async active-low reset             |
// |               s_r*                slave-side R channels (slave k at slice k) |
// |               m_r*                master-side R channel                      |
// |               rgrant              one-hot current grant (0 when idle)        |
// |               busy                high while a burst is owned                |
// |               burst_cnt           per-slave 16-bit completed-burst counters  |
// |                                   (only with AXI_RD_ARB_CNT_EN defined)      |
// | Config      : AXI_RD_ARB_CNT_EN  enables burst_cnt port and counters         |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module axi_rd_burst_arbiter
   import axi_ic_pkg::*;
#(
   parameter int N_SLV  = 3,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                    sys_clk,
   input  logic                    sys_rstn,
   input  logic [N_SLV-1:0]        s_rvalid,
   input  logic [N_SLV*DATA_W-1:0] s_rdata,
   input  logic [N_SLV*2-1:0]      s_rresp,
   input  logic [N_SLV-1:0]        s_rlast,
   input  logic [N_SLV*ID_W-1:0]   s_rid,
   output logic [N_SLV-1:0]        s_rready,
   output logic                    m_rvalid,
   output logic [DATA_W-1:0]       m_rdata,
   output logic [1:0]              m_rresp,
   output logic                    m_rlast,
   output logic [ID_W-1:0]         m_rid,
   input  logic                    m_rready,
   output logic [N_SLV-1:0]        rgrant,
   output logic                    busy
`ifdef AXI_RD_ARB_CNT_EN
   ,
   output logic [N_SLV*ARB_CNT_W-1:0] burst_cnt
`endif
);

   localparam int PTR_W = $clog2(N_SLV);

   arb_state_e         state_q, state_d;
   logic [N_SLV-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]   ptr_q,   ptr_d;
   logic [N_SLV-1:0]   pick_gnt;
   logic [PTR_W-1:0]   pick_idx;
   logic               rlast_hs;

   rr_pick #(
      .N_REQ (N_SLV),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_i (s_rvalid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt)
   );

   // Binary index of the picked slave, used to advance the pointer.
   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (pick_gnt[k]) begin
            pick_idx = PTR_W'(k);
         end
      end
   end

   // State register
   always_ff @(posedge sys_clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         ARB_IDLE: begin
            if (|s_rvalid) begin
               grant_d = pick_gnt;
               ptr_d   = (pick_idx == PTR_W'(N_SLV - 1)) ? '0 : (pick_idx + PTR_W'(1));
               state_d = ARB_BURST;
            end
         end
         ARB_BURST: begin
            if (rlast_hs) begin
               grant_d = '0;
               state_d = ARB_IDLE;
            end
         end
         default: begin
            grant_d = '0;
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Output logic: zero-latency mux from the granted slave. grant_q is zero
   // in IDLE and during reset, so every output falls back to 0 there.
   always_comb begin
      m_rvalid = 1'b0;
      m_rdata  = '0;
      m_rresp  = '0;
      m_rlast  = 1'b0;
      m_rid    = '0;
      s_rready = '0;
      for (int k = 0; k < N_SLV; k++) begin
         if (grant_q[k]) begin
            m_rvalid    = s_rvalid[k];
            m_rdata     = s_rdata[k*DATA_W +: DATA_W];
            m_rresp     = s_rresp[k*2 +: 2];
            m_rlast     = s_rlast[k];
            m_rid       = s_rid[k*ID_W +: ID_W];
            s_rready[k] = m_rready;
         end
      end
   end

   assign rlast_hs = m_rvalid & m_rready & m_rlast;
   assign rgrant   = grant_q;
   assign busy     = (state_q == ARB_BURST);

`ifdef AXI_RD_ARB_CNT_EN
   for (genvar k = 0; k < N_SLV; k++) begin : g_cnt
      logic [ARB_CNT_W-1:0] cnt_q;

      // Free-running wrap at 0xFFFF -> 0 is intentional.
      always_ff @(posedge sys_clk or negedge sys_rstn) begin
         if (!sys_rstn) begin
            cnt_q <= '0;
         end else if (grant_q[k] && rlast_hs) begin
            cnt_q <= cnt_q + ARB_CNT_W'(1);
         end
      end

      assign burst_cnt[k*ARB_CNT_W +: ARB_CNT_W] = cnt_q;
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_burst_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_axi_rd_burst_arbiter                                        |
// | Description : Scoreboard bench for axi_rd_burst_arbiter. Slave queues feed   |
// |               the slave R ports; expected master beats are queued in         |
// |               arbitration order and compared by an independent monitor.      |
// | Config      : AXI_RD_ARB_CNT_EN  also checks burst_cnt                       |
// | Revision    : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_axi_rd_burst_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int IW = 4;

   typedef struct packed {
      logic [1:0]    slv;
      logic [DW-1:0] data;
      logic [1:0]    resp;
      logic          last;
      logic [IW-1:0] id;
   } beat_t;

   logic            sys_clk = 1'b0;
   logic            sys_rstn;
   logic [N-1:0]    s_rvalid;
   logic [N*DW-1:0] s_rdata;
   logic [N*2-1:0]  s_rresp;
   logic [N-1:0]    s_rlast;
   logic [N*IW-1:0] s_rid;
   logic [N-1:0]    s_rready;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic [1:0]      m_rresp;
   logic            m_rlast;
   logic [IW-1:0]   m_rid;
   logic            m_rready;
   logic [N-1:0]    rgrant;
   logic            busy;
`ifdef AXI_RD_ARB_CNT_EN
   logic [N*16-1:0] burst_cnt;
`endif

   int    vec_cnt = 0;
   int    err_cnt = 0;
   logic  drv_on  = 1'b0;
   beat_t slv_q [N][$];
   beat_t sb [$];

   always #5 sys_clk = ~sys_clk;

   axi_rd_burst_arbiter #(
      .N_SLV  (N),
      .DATA_W (DW),
      .ID_W   (IW)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rstn  (sys_rstn),
      .s_rvalid  (s_rvalid),
      .s_rdata   (s_rdata),
      .s_rresp   (s_rresp),
      .s_rlast   (s_rlast),
      .s_rid     (s_rid),
      .s_rready  (s_rready),
      .m_rvalid  (m_rvalid),
      .m_rdata   (m_rdata),
      .m_rresp   (m_rresp),
      .m_rlast   (m_rlast),
      .m_rid     (m_rid),
      .m_rready  (m_rready),
      .rgrant    (rgrant),
      .busy      (busy)
`ifdef AXI_RD_ARB_CNT_EN
      ,
      .burst_cnt (burst_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic beat_t make_beat(input int slv, input int n, input int i, input logic [DW-1:0] base);
      beat_t b;
      b.slv  = 2'(slv);
      b.data = base + DW'(i);
      b.resp = 2'(i);
      b.last = (i == n - 1);
      b.id   = IW'(4 * slv + i);
      return b;
   endfunction

   task automatic add_slave_burst(input int slv, input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) slv_q[slv].push_back(make_beat(slv, n, i, base));
   endtask

   task automatic expect_burst(input int slv, input int n, input logic [DW-1:0] base);
      for (int i = 0; i < n; i++) sb.push_back(make_beat(slv, n, i, base));
   endtask

   task automatic drain(input string name);
      int left;
      left = 1;
      for (int i = 0; i < 400 && left != 0; i++) begin
         @(negedge sys_clk);
         left = sb.size() + slv_q[0].size() + slv_q[1].size() + slv_q[2].size();
      end
      check(name, 64'(left), 64'd0);
   endtask

   // Slave-side driver: present the front beat of each slave queue, pop on handshake.
   initial begin : p_driver
      logic [N-1:0] hs;
      beat_t        b;
      s_rvalid = '1;
      s_rdata  = '0;
      s_rresp  = '0;
      s_rlast  = '0;
      s_rid    = '0;
      wait (drv_on);
      s_rvalid = '0;
      forever begin
         @(negedge sys_clk);
         hs = s_rvalid & s_rready;
         @(posedge sys_clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (hs[k] && slv_q[k].size() > 0) void'(slv_q[k].pop_front());
            if (slv_q[k].size() > 0) begin
               b = slv_q[k][0];
               s_rvalid[k]            = 1'b1;
               s_rdata[k*DW +: DW]    = b.data;
               s_rresp[k*2 +: 2]      = b.resp;
               s_rlast[k]             = b.last;
               s_rid[k*IW +: IW]      = b.id;
            end else begin
               s_rvalid[k]            = 1'b0;
               s_rdata[k*DW +: DW]    = '0;
               s_rresp[k*2 +: 2]      = '0;
               s_rlast[k]             = 1'b0;
               s_rid[k*IW +: IW]      = '0;
            end
         end
      end
   end

   // Monitor: every master-side handshake must match the next expected beat.
   initial begin : p_monitor
      beat_t        e;
      logic [N-1:0] eg;
      forever begin
         @(negedge sys_clk);
         if (sys_rstn === 1'b1 && m_rvalid === 1'b1 && m_rready === 1'b1) begin
            if (sb.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL unexpected_beat: got data %h grant %b, expected no beat", m_rdata, rgrant);
            end else begin
               e  = sb.pop_front();
               eg = N'(1) << e.slv;
               check("beat {grant,data,resp,last,id}",
                     64'({rgrant, m_rdata, m_rresp, m_rlast, m_rid}),
                     64'({eg, e.data, e.resp, e.last, e.id}));
            end
         end
      end
   end

   initial begin : p_watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      logic [16:0] pat, pexp;
      int          cnt;
      sys_rstn = 1'b0;
      m_rready = 1'b1;

      // Reset with all slaves requesting
      repeat (3) @(negedge sys_clk);
      check("reset rgrant",   64'(rgrant),   64'd0);
      check("reset m_rvalid", 64'(m_rvalid), 64'd0);
      check("reset s_rready", 64'(s_rready), 64'd0);
      check("reset busy",     64'(busy),     64'd0);
      drv_on   = 1'b1;
      sys_rstn = 1'b1;
      repeat (2) @(negedge sys_clk);

      // Round robin: all three request two 2-beat bursts, ptr starts at 0
      #2;
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < N; s++) begin
            add_slave_burst(s, 2, DW'(32'h100 * (s + 1) + 16 * r));
            expect_burst(s, 2, DW'(32'h100 * (s + 1) + 16 * r));
         end
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (m_rvalid) break;
      end
      pat[0]  = m_rvalid;
      pexp[0] = 1'b1;
      for (int i = 1; i < 17; i++) begin
         @(negedge sys_clk);
         pat[i]  = m_rvalid;
         pexp[i] = ((i % 3) != 2);
      end
      check("rr bubble pattern", 64'(pat), 64'(pexp));
      drain("rr drain");
      check("rr idle grant", 64'({rgrant, busy}), 64'd0);

      // Single slave s1, 4-beat burst 0xA0..0xA3 (ptr now 0)
      #2;
      add_slave_burst(1, 4, 32'hA0);
      expect_burst(1, 4, 32'hA0);
      @(posedge sys_clk); #2;
      check("s1 request cycle {grant,m_rvalid}", 64'({rgrant, m_rvalid}), 64'd0);
      @(posedge sys_clk); #2;
      check("s1 grant latency {grant,m_rvalid,busy}", 64'({rgrant, m_rvalid, busy}), 64'({3'b010, 1'b1, 1'b1}));
      drain("s1 drain");
      check("s1 idle {grant,busy}", 64'({rgrant, busy}), 64'd0);

      // Backpressure on s2 burst: m_rready toggles
      #2;
      add_slave_burst(2, 4, 32'hC0);
      expect_burst(2, 4, 32'hC0);
      for (int i = 0; i < 12; i++) begin
         @(posedge sys_clk); #2;
         m_rready = ((i % 2) == 0);
         @(negedge sys_clk);
         if (rgrant[2]) check("bp s_rready mirror", 64'(s_rready), 64'({m_rready, 2'b00}));
      end
      m_rready = 1'b1;
      drain("bp drain");

      // No interleave: s1 requests during s0's 8-beat burst (ptr now 0)
      #2;
      add_slave_burst(0, 8, 32'hD0);
      expect_burst(0, 8, 32'hD0);
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 8; i++) begin
         @(negedge sys_clk);
         if (cnt >= 3 && rgrant[0]) check("noint s1 stalled", 64'(s_rready), 64'b001);
         if (s_rvalid[0] && s_rready[0]) begin
            cnt++;
            if (cnt == 2) begin
               add_slave_burst(1, 2, 32'hE0);
               expect_burst(1, 2, 32'hE0);
            end
         end
      end
      drain("noint drain");

      // Reset mid-burst: s0 wins (ptr -> 1), reset after 3 beats
      #2;
      add_slave_burst(0, 8, 32'h50);
      expect_burst(0, 8, 32'h50);
      cnt = 0;
      for (int i = 0; i < 40 && cnt < 3; i++) begin
         @(negedge sys_clk);
         if (s_rvalid[0] && s_rready[0]) cnt++;
      end
      #2;
      sys_rstn = 1'b0;
      #1;
      check("midrst {grant,busy,s_rready,m_rvalid}", 64'({rgrant, busy, s_rready, m_rvalid}), 64'd0);
      check("midrst {m_rdata,m_rresp,m_rlast,m_rid}", 64'({m_rdata, m_rresp, m_rlast, m_rid}), 64'd0);
      slv_q[0].delete();
      sb.delete();
      repeat (2) @(negedge sys_clk);
      #2;
      add_slave_burst(0, 2, 32'h60);
      add_slave_burst(1, 2, 32'h70);
      expect_burst(0, 2, 32'h60);
      expect_burst(1, 2, 32'h70);
      sys_rstn = 1'b1;
      drain("midrst drain");

      // Five single-beat bursts from s2 after a fresh reset
      sys_rstn = 1'b0;
      @(negedge sys_clk);
      sys_rstn = 1'b1;
      @(negedge sys_clk);
      #2;
      for (int i = 0; i < 5; i++) begin
         add_slave_burst(2, 1, DW'(32'h90 + 16 * i));
         expect_burst(2, 1, DW'(32'h90 + 16 * i));
      end
      drain("single drain");
      check("single idle {grant,busy}", 64'({rgrant, busy}), 64'd0);
`ifdef AXI_RD_ARB_CNT_EN
      check("burst_cnt", 64'(burst_cnt), 64'({16'd5, 16'd0, 16'd0}));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire
